// File: rtl/linear_combo_pkg.sv
// Shared types and helpers for linear_combo_unit (FSM states, accumulator width, result narrowing).
// Defining LINEAR_COMBO_SATURATE_EN makes sat_trunc clamp out-of-range values instead of wrapping them.
package linear_combo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HELPER_W = 64;

  function automatic int acc_width(input int width, input int coef_w);
    return width + coef_w + 1;
  endfunction

  // Returns a value whose low 'width' bits are the narrowed result.
  function automatic logic signed [HELPER_W-1:0] sat_trunc(
    input logic signed [HELPER_W-1:0] acc,
    input int                         width
  );
`ifdef LINEAR_COMBO_SATURATE_EN
    logic signed [HELPER_W-1:0] maxV;
    logic signed [HELPER_W-1:0] minV;
    maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (width - 1));
    if (acc > maxV) return maxV;
    if (acc < minV) return minV;
    return acc;
`else
    return (acc <<< (HELPER_W - width)) >>> (HELPER_W - width);
`endif
  endfunction

endpackage

// File: rtl/linear_combo_unit_shift_add_step.sv
// One shift-add iteration: adds a<<<step when bit_a is set and subtracts b<<<step when bit_b is set.
module shift_add_step #(
  parameter int ACC_W  = 13,
  parameter int STEP_W = 2
) (
  input  logic signed [ACC_W-1:0]  a_i,
  input  logic signed [ACC_W-1:0]  b_i,
  input  logic                     bit_a_i,
  input  logic                     bit_b_i,
  input  logic        [STEP_W-1:0] step_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [ACC_W-1:0] termA;
  logic signed [ACC_W-1:0] termB;

  always_comb begin
    termA = bit_a_i ? (a_i <<< step_i) : '0;
    termB = bit_b_i ? (b_i <<< step_i) : '0;
    acc_o = acc_i + termA - termB;
  end

endmodule

// File: rtl/linear_combo_unit.sv
// Sequential coef_a*dado01 - coef_b*dado02, one coefficient bit per cycle, valid/ready on both sides.
// Build with LINEAR_COMBO_SATURATE_EN to clamp dado03 on overflow instead of wrapping.
module linear_combo_unit
  import linear_combo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int COEF_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  dado01,
  input  logic [WIDTH-1:0]  dado02,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  dado03,
  output logic              overflow,
  output logic              busy
);

  localparam int ACC_W  = acc_width(WIDTH, COEF_W);
  localparam int STEP_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;
  localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(COEF_W - 1);
  localparam logic signed [ACC_W-1:0] MAX_V   = ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN_V   = ACC_W'(-(64'sd1 <<< (WIDTH - 1)));

  state_t                   state_q;
  logic signed [ACC_W-1:0]  a_q;
  logic signed [ACC_W-1:0]  b_q;
  logic [COEF_W-1:0]        coefA_q;
  logic [COEF_W-1:0]        coefB_q;
  logic [STEP_W-1:0]        step_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [WIDTH-1:0]         dado03_q;
  logic                     overflow_q;
  logic                     outValid_q;

  logic signed [ACC_W-1:0]    aExt;
  logic signed [ACC_W-1:0]    bExt;
  logic signed [HELPER_W-1:0] accWide;
  logic [WIDTH-1:0]           result_d;
  logic                       overflow_d;

  assign aExt = {{(ACC_W-WIDTH){dado01[WIDTH-1]}}, dado01};
  assign bExt = {{(ACC_W-WIDTH){dado02[WIDTH-1]}}, dado02};

  shift_add_step #(
    .ACC_W (ACC_W),
    .STEP_W(STEP_W)
  ) u_step (
    .a_i    (a_q),
    .b_i    (b_q),
    .bit_a_i(coefA_q[step_q]),
    .bit_b_i(coefB_q[step_q]),
    .step_i (step_q),
    .acc_i  (acc_q),
    .acc_o  (acc_d)
  );

  // Result and flag are formed from the accumulator value that the final step produces.
  assign accWide    = {{(HELPER_W-ACC_W){acc_d[ACC_W-1]}}, acc_d};
  assign result_d   = WIDTH'(sat_trunc(accWide, WIDTH));
  assign overflow_d = (acc_d > MAX_V) || (acc_d < MIN_V);

  // In DONE the unit can take new operands in the same edge the result is popped.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign dado03    = dado03_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      coefA_q    <= '0;
      coefB_q    <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      dado03_q   <= '0;
      overflow_q <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= aExt;
            b_q     <= bExt;
            coefA_q <= coef_a;
            coefB_q <= coef_b;
            acc_q   <= '0;
            step_q  <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          step_q <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            dado03_q   <= result_d;
            overflow_q <= overflow_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            if (in_valid) begin
              a_q     <= aExt;
              b_q     <= bExt;
              coefA_q <= coef_a;
              coefB_q <= coef_b;
              acc_q   <= '0;
              step_q  <= '0;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_combo_unit.sv
// Directed self-checking bench for linear_combo_unit at WIDTH=8, COEF_W=4 (wrap or saturate build).
module tb_linear_combo_unit;

  localparam int WIDTH  = 8;
  localparam int COEF_W = 4;
`ifdef LINEAR_COMBO_SATURATE_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  dado01;
  logic [WIDTH-1:0]  dado02;
  logic [COEF_W-1:0] coef_a;
  logic [COEF_W-1:0] coef_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  dado03;
  logic              overflow;
  logic              busy;

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ca;
    logic [3:0] cb;
    logic [7:0] wrapRes;
    logic [7:0] satRes;
    logic       ovf;
  } vec_t;

  always #5 clk = ~clk;

  linear_combo_unit #(
    .WIDTH (WIDTH),
    .COEF_W(COEF_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dado01   (dado01),
    .dado02   (dado02),
    .coef_a   (coef_a),
    .coef_b   (coef_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dado03   (dado03),
    .overflow (overflow),
    .busy     (busy)
  );

  // Presents operands and returns #1 after the edge that accepted them.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] ca, input logic [3:0] cb);
    int waited;
    dado01   = a;
    dado02   = b;
    coef_a   = ca;
    coef_b   = cb;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic popResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dado01    = '0;
    dado02    = '0;
    coef_a    = '0;
    coef_b    = '0;
    #12;
    compareCount++;
    if ({in_ready, out_valid, overflow, busy} !== 4'b1000) begin
      mismatchCount++;
      $display("[TB] FAIL reset_flags: {in_ready,out_valid,overflow,busy}=%b required 1000",
               {in_ready, out_valid, overflow, busy});
    end
    compareCount++;
    if (dado03 !== 8'h00) begin
      mismatchCount++;
      $display("[TB] FAIL reset_dado03: got %h required 00", dado03);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compareCount++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      mismatchCount++;
      $display("[TB] FAIL idle_out_ready: {out_valid,busy,in_ready}=%b required 001",
               {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_basic();
    int lat;
    applyStimulus(8'd5, 8'd3, 4'd3, 4'd2);
    compareCount++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      mismatchCount++;
      $display("[TB] FAIL basic_calc_flags: {busy,in_ready,out_valid}=%b required 100",
               {busy, in_ready, out_valid});
    end
    waitResult(lat);
    compareCount++;
    if (lat !== 4) begin
      mismatchCount++;
      $display("[TB] FAIL basic_latency: got %0d required 4", lat);
    end
    compareCount++;
    if ({overflow, dado03} !== {1'b0, 8'd9}) begin
      mismatchCount++;
      $display("[TB] FAIL basic_result: got ovf=%0b %h required ovf=0 09", overflow, dado03);
    end
    popResult();
    compareCount++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      mismatchCount++;
      $display("[TB] FAIL basic_pop: {out_valid,busy,in_ready}=%b required 001",
               {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_patterns();
    vec_t vecs [9];
    int   lat;
    logic [7:0] expRes;
    vecs[0] = '{8'hFC, 8'h02, 4'd3,  4'd2, 8'hF0, 8'hF0, 1'b0};
    vecs[1] = '{8'h07, 8'h01, 4'd3,  4'd2, 8'h13, 8'h13, 1'b0};
    vecs[2] = '{8'h05, 8'h03, 4'd0,  4'd0, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h00, 4'd1,  4'd0, 8'h80, 8'h80, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 4'd1,  4'd1, 8'h7F, 8'h80, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 4'd1,  4'd1, 8'h80, 8'h7F, 1'b1};
    vecs[6] = '{8'h00, 8'h01, 4'd0,  4'd1, 8'hFF, 8'hFF, 1'b0};
    vecs[7] = '{8'h03, 8'h05, 4'd10, 4'd5, 8'h05, 8'h05, 1'b0};
    vecs[8] = '{8'hF0, 8'h00, 4'd8,  4'd0, 8'h80, 8'h80, 1'b0};
    for (int i = 0; i < 9; i++) begin
      expRes = SAT_MODE ? vecs[i].satRes : vecs[i].wrapRes;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ca, vecs[i].cb);
      waitResult(lat);
      compareCount++;
      if ({lat[3:0], overflow, dado03} !== {4'd4, vecs[i].ovf, expRes}) begin
        mismatchCount++;
        $display("[TB] FAIL pattern_%0d: got lat=%0d ovf=%0b %h required lat=4 ovf=%0b %h",
                 i, lat, overflow, dado03, vecs[i].ovf, expRes);
      end
      popResult();
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [7:0] expRes;
    expRes = SAT_MODE ? 8'h7F : 8'hF1;
    applyStimulus(8'd127, 8'h80, 4'd15, 4'd15);
    waitResult(lat);
    compareCount++;
    if (overflow !== 1'b1) begin
      mismatchCount++;
      $display("[TB] FAIL overflow_flag: got %0b required 1", overflow);
    end
    compareCount++;
    if (dado03 !== expRes) begin
      mismatchCount++;
      $display("[TB] FAIL overflow_result: got %h required %h", dado03, expRes);
    end
    popResult();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    applyStimulus(8'd7, 8'd1, 4'd3, 4'd2);
    waitResult(lat);
    dado01   = 8'd1;
    dado02   = 8'd1;
    coef_a   = 4'd1;
    coef_b   = 4'd0;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      compareCount++;
      if ({out_valid, in_ready, busy, dado03} !== {3'b101, 8'h13}) begin
        mismatchCount++;
        bad++;
        if (bad < 4)
          $display("[TB] FAIL hold_cycle_%0d: {out_valid,in_ready,busy}=%b dado03=%h required 101 13",
                   i, {out_valid, in_ready, busy}, dado03);
      end
    end
    in_valid = 1'b0;
    popResult();
    compareCount++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      mismatchCount++;
      $display("[TB] FAIL hold_release: {out_valid,busy,in_ready}=%b required 001",
               {out_valid, busy, in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compareCount++;
      if (out_valid !== 1'b0) begin
        mismatchCount++;
        $display("[TB] FAIL hold_single_pop_%0d: out_valid=%0b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    applyStimulus(8'd5, 8'd3, 4'd3, 4'd2);
    waitResult(lat);
    compareCount++;
    if (dado03 !== 8'd9) begin
      mismatchCount++;
      $display("[TB] FAIL b2b_first: got %h required 09", dado03);
    end
    dado01    = 8'hFC;
    dado02    = 8'h02;
    coef_a    = 4'd3;
    coef_b    = 4'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    compareCount++;
    if (in_ready !== 1'b1) begin
      mismatchCount++;
      $display("[TB] FAIL b2b_in_ready: got %0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compareCount++;
    if ({out_valid, busy} !== 2'b01) begin
      mismatchCount++;
      $display("[TB] FAIL b2b_restart: {out_valid,busy}=%b required 01", {out_valid, busy});
    end
    waitResult(lat);
    compareCount++;
    if ({lat[3:0], dado03} !== {4'd4, 8'hF0}) begin
      mismatchCount++;
      $display("[TB] FAIL b2b_second: got lat=%0d %h required lat=4 f0", lat, dado03);
    end
    popResult();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compareCount++;
      if ({out_valid, busy} !== 2'b00) begin
        mismatchCount++;
        $display("[TB] FAIL b2b_no_dup_%0d: {out_valid,busy}=%b required 00", i, {out_valid, busy});
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    applyStimulus(8'd127, 8'h80, 4'd15, 4'd15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    compareCount++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      mismatchCount++;
      $display("[TB] FAIL midreset_flags: {out_valid,busy,in_ready}=%b required 001",
               {out_valid, busy, in_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'd5, 8'd3, 4'd3, 4'd2);
    waitResult(lat);
    compareCount++;
    if ({lat[3:0], overflow, dado03} !== {4'd4, 1'b0, 8'd9}) begin
      mismatchCount++;
      $display("[TB] FAIL midreset_next: got lat=%0d ovf=%0b %h required lat=4 ovf=0 09",
               lat, overflow, dado03);
    end
    popResult();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
